// File: rtl/sonar_varredura_n.sv
// Sonar sweep controller: measures range at each servo position and sends an 8-char ASCII frame per position.
// Outputs are registered; serial transmit is paced by a partida_tx/pronto_tx handshake, one character at a time.
module sonar_varredura_n #(
  parameter int N_POS     = 8,
  parameter int W_POS     = 3,
  parameter int T_ESPERA  = 100_000_000,
  parameter int T_TIMEOUT = 10_000_000,
  parameter int N_TENT    = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ligar,
  input  logic             modo,
  input  logic [11:0]      medida,
  input  logic             pronto_medida,
  input  logic [20:0]      angulo_ascii,
  input  logic             pronto_tx,
  output logic             medir,
  output logic             partida_tx,
  output logic [6:0]       dados_ascii,
  output logic [W_POS-1:0] posicao,
  output logic             fim_quadro,
  output logic             falha_medida,
  output logic [3:0]       db_estado
);

  localparam int T_MAX = (T_ESPERA > T_TIMEOUT) ? T_ESPERA : T_TIMEOUT;
  localparam int W_CNT = $clog2(T_MAX + 1);
  localparam logic [W_POS-1:0] P_ULT = W_POS'(N_POS - 1);

  typedef enum logic [2:0] {
    INICIAL        = 3'd0,
    MEDE           = 3'd1,
    AGUARDA_MEDIDA = 3'd2,
    TRANSMITE      = 3'd3,
    AGUARDA_TX     = 3'd4,
    ESPERA         = 3'd5,
    AVANCA         = 3'd6
  } estado_t;

  estado_t          r_estado;
  estado_t          w_prox;
  logic [W_CNT-1:0] r_cnt;
  logic [3:0]       r_tent;
  logic [2:0]       r_idx;
  logic [20:0]      r_ang;
  logic [11:0]      r_med;
  logic             r_falha;
  logic             r_desce;
  logic             r_medir;
  logic             r_partida;
  logic             r_fim;
  logic [6:0]       r_dados;
  logic [W_POS-1:0] r_pos;

  logic             w_tmo;
  logic             w_esp_fim;
  logic             w_inicio;
  logic [2:0]       w_idx_nxt;
  logic [3:0]       w_nib;
  logic [6:0]       w_char;
  logic [W_POS-1:0] w_pos_nxt;
  logic             w_desce_nxt;

  // r_cnt reads 0 during MEDE, so a timeout lands T_TIMEOUT cycles after medir.
  assign w_tmo     = (r_cnt == W_CNT'(T_TIMEOUT - 1));
  assign w_esp_fim = (r_cnt == W_CNT'(T_ESPERA - 1));
  assign w_inicio  = (w_prox == MEDE) && ((r_estado == INICIAL) || (r_estado == AVANCA));

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      INICIAL:        if (ligar) w_prox = MEDE;
      MEDE:           w_prox = AGUARDA_MEDIDA;
      AGUARDA_MEDIDA: begin
        if (pronto_medida) w_prox = TRANSMITE;
        else if (w_tmo)    w_prox = (r_tent < 4'(N_TENT)) ? MEDE : TRANSMITE;
      end
      TRANSMITE:      w_prox = AGUARDA_TX;
      AGUARDA_TX:     if (pronto_tx) w_prox = (r_idx == 3'd7) ? ESPERA : TRANSMITE;
      ESPERA: begin
        if (!ligar)         w_prox = INICIAL;
        else if (w_esp_fim) w_prox = AVANCA;
      end
      AVANCA:         w_prox = ligar ? MEDE : INICIAL;
      default:        w_prox = INICIAL;
    endcase
  end

  always_comb begin
    w_idx_nxt = (r_estado == AGUARDA_TX) ? r_idx + 3'd1 : 3'd0;
    w_nib     = 4'h0;
    w_char    = 7'h23;
    case (w_idx_nxt)
      3'd0: w_char = r_ang[20:14];
      3'd1: w_char = r_ang[13:7];
      3'd2: w_char = r_ang[6:0];
      3'd3: w_char = 7'h2C;
      3'd4, 3'd5, 3'd6: begin
        if (w_idx_nxt == 3'd4)      w_nib = r_med[11:8];
        else if (w_idx_nxt == 3'd5) w_nib = r_med[7:4];
        else                        w_nib = r_med[3:0];
        w_char = r_falha ? 7'h3F : ({3'b000, w_nib} + 7'h30);
      end
      default: w_char = 7'h23;
    endcase
  end

  // Ping-pong turns around on the endpoint itself, so each endpoint is visited once per pass.
  always_comb begin
    w_pos_nxt   = r_pos;
    w_desce_nxt = r_desce;
    if (!modo) begin
      w_pos_nxt = (r_pos == P_ULT) ? '0 : r_pos + 1'b1;
    end else if (!r_desce && (r_pos == P_ULT)) begin
      w_pos_nxt   = r_pos - 1'b1;
      w_desce_nxt = 1'b1;
    end else if (r_desce && (r_pos == '0)) begin
      w_pos_nxt   = r_pos + 1'b1;
      w_desce_nxt = 1'b0;
    end else begin
      w_pos_nxt = r_desce ? r_pos - 1'b1 : r_pos + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado  <= INICIAL;
      r_cnt     <= '0;
      r_tent    <= '0;
      r_idx     <= '0;
      r_ang     <= '0;
      r_med     <= '0;
      r_falha   <= 1'b0;
      r_desce   <= 1'b0;
      r_medir   <= 1'b0;
      r_partida <= 1'b0;
      r_fim     <= 1'b0;
      r_dados   <= '0;
      r_pos     <= '0;
    end else begin
      r_estado  <= w_prox;
      r_medir   <= (w_prox == MEDE);
      r_partida <= (w_prox == TRANSMITE);
      r_fim     <= (r_estado == AGUARDA_TX) && (w_prox == ESPERA);

      if ((w_prox == MEDE) || ((w_prox == ESPERA) && (r_estado != ESPERA)))
        r_cnt <= '0;
      else if ((r_estado == MEDE) || (r_estado == AGUARDA_MEDIDA) || (r_estado == ESPERA))
        r_cnt <= r_cnt + 1'b1;

      if ((r_estado == INICIAL) || (r_estado == AVANCA)) r_tent <= '0;
      else if (r_estado == MEDE)                          r_tent <= r_tent + 4'd1;

      if (w_inicio) r_ang <= angulo_ascii;

      if (r_estado == AGUARDA_MEDIDA) begin
        if (pronto_medida) begin
          r_med   <= medida;
          r_falha <= 1'b0;
        end else if (w_tmo && (r_tent >= 4'(N_TENT))) begin
          r_falha <= 1'b1;
        end
      end else if (w_prox == INICIAL) begin
        r_falha <= 1'b0;
      end

      if (r_estado == AGUARDA_MEDIDA)                r_idx <= '0;
      else if ((r_estado == AGUARDA_TX) && pronto_tx) r_idx <= r_idx + 3'd1;

      if (w_prox == TRANSMITE)    r_dados <= w_char;
      else if (w_prox == INICIAL) r_dados <= '0;

      if (r_estado == AVANCA) begin
        r_pos   <= w_pos_nxt;
        r_desce <= w_desce_nxt;
      end
    end
  end

  assign medir        = r_medir;
  assign partida_tx   = r_partida;
  assign dados_ascii  = r_dados;
  assign posicao      = r_pos;
  assign fim_quadro   = r_fim;
  assign falha_medida = r_falha;
  assign db_estado    = {1'b0, r_estado};

endmodule

// File: tb/tb_sonar_varredura_n.sv
// Bench for sonar_varredura_n: drives measurement/serial responders and checks frames against a frame/sweep model.
module tb_sonar_varredura_n;
  localparam int N_POS = 4, W_POS = 2, T_ESPERA = 20, T_TIMEOUT = 10, N_TENT = 2;

  logic clk = 1'b0, rst = 1'b0, ligar = 1'b0, modo = 1'b0;
  logic pronto_medida = 1'b0, pronto_tx = 1'b0;
  logic [11:0] medida = '0;
  logic [20:0] angulo_ascii = '0;
  logic medir, partida_tx, fim_quadro, falha_medida;
  logic [6:0] dados_ascii;
  logic [W_POS-1:0] posicao;
  logic [3:0] db_estado;

  int n_tests = 0, n_fail = 0;

  logic [6:0] obs_ch [8];
  int obs_nch, obs_nmedir, obs_gap, obs_nfim, obs_unstable;
  logic obs_falha;
  logic [W_POS-1:0] obs_pos;
  bit obs_expired;

  sonar_varredura_n #(.N_POS(N_POS), .W_POS(W_POS), .T_ESPERA(T_ESPERA),
                      .T_TIMEOUT(T_TIMEOUT), .N_TENT(N_TENT)) dut (
    .clock(clk), .reset(rst), .ligar(ligar), .modo(modo), .medida(medida),
    .pronto_medida(pronto_medida), .angulo_ascii(angulo_ascii), .pronto_tx(pronto_tx),
    .medir(medir), .partida_tx(partida_tx), .dados_ascii(dados_ascii), .posicao(posicao),
    .fim_quadro(fim_quadro), .falha_medida(falha_medida), .db_estado(db_estado));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; ligar = 1'b0; modo = 1'b0; pronto_medida = 1'b0; pronto_tx = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  function automatic logic [6:0] exp_char(input int i, input logic [20:0] a,
                                          input logic [11:0] m, input bit fail);
    logic [3:0] nib;
    nib = (i == 4) ? m[11:8] : (i == 5) ? m[7:4] : m[3:0];
    case (i)
      0: return a[20:14];
      1: return a[13:7];
      2: return a[6:0];
      3: return 7'h2C;
      4, 5, 6: return fail ? 7'h3F : 7'h30 + 7'(nib);
      default: return 7'h23;
    endcase
  endfunction

  // Environment for one frame: answers medir after dly cycles (dly<=0: never), answers each
  // partida_tx 3 cycles later, returns at the fim_quadro cycle.
  task automatic do_frame(input int dly, input logic [11:0] med, input logic [20:0] ang,
                          input int drop_at, input bit spurious);
    int med_cd, tx_cd, t1;
    bit done, drop_pend;
    logic [6:0] held;
    medida = med; angulo_ascii = ang;
    med_cd = -1; tx_cd = -1; t1 = 0; done = 0; drop_pend = 0; held = '0;
    obs_nch = 0; obs_nmedir = 0; obs_gap = -1; obs_nfim = 0; obs_unstable = 0;
    obs_falha = 1'b0; obs_pos = '0; obs_expired = 1'b1;
    for (int i = 0; i < 8; i++) obs_ch[i] = 7'h00;
    for (int t = 0; t < 600 && !done; t++) begin
      step();
      pronto_medida = 1'b0;
      pronto_tx = 1'b0;
      if (medir) begin
        obs_nmedir++;
        if (obs_nmedir == 1) begin
          obs_pos = posicao;
          t1 = t;
          angulo_ascii = 21'($urandom);
        end else if (obs_nmedir == 2) begin
          obs_gap = t - t1;
        end
        med_cd = (dly > 0) ? dly : -1;
        if (spurious) pronto_tx = 1'b1;
      end
      if (med_cd >= 0) begin
        pronto_medida = (med_cd == 0);
        med_cd--;
      end
      if (partida_tx) begin
        if (obs_nch < 8) obs_ch[obs_nch] = dados_ascii;
        held = dados_ascii;
        obs_nch++;
        tx_cd = 3;
        if (obs_nch - 1 == drop_at) drop_pend = 1;
      end else begin
        if (tx_cd >= 0 && dados_ascii !== held) obs_unstable++;
        if (drop_pend) begin
          ligar = 1'b0;
          drop_pend = 0;
        end
      end
      if (tx_cd >= 0) begin
        pronto_tx = pronto_tx | (tx_cd == 0);
        tx_cd--;
      end
      if (fim_quadro) begin
        obs_nfim++;
        obs_falha = falha_medida;
        obs_expired = 1'b0;
        done = 1;
      end
    end
    pronto_medida = 1'b0;
    pronto_tx = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ligar = 1'b1;
    step(); step(); step();
    n_tests++;
    if ({medir, partida_tx, fim_quadro, falha_medida, dados_ascii, posicao, db_estado} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got st=%0d pos=%0d dados=%h medir=%b partida=%b fim=%b falha=%b, want all 0",
               db_estado, posicao, dados_ascii, medir, partida_tx, fim_quadro, falha_medida);
    end
    rst = 1'b0; ligar = 1'b0;
    step(); step();
    n_tests++;
    if (db_estado !== 4'd0) begin n_fail++; $display("FAIL idle_hold: got st=%0d want 0", db_estado); end
    ligar = 1'b1;
    step();
    n_tests++;
    if (db_estado !== 4'd1 || medir !== 1'b1) begin
      n_fail++; $display("FAIL start_mede: got st=%0d medir=%b want st=1 medir=1", db_estado, medir);
    end
    step();
    n_tests++;
    if (db_estado !== 4'd2 || medir !== 1'b0) begin
      n_fail++; $display("FAIL medir_pulse: got st=%0d medir=%b want st=2 medir=0", db_estado, medir);
    end
  endtask

  task automatic test_basic_frame();
    logic [6:0] want [8];
    bit seen;
    want = '{7'h30, 7'h34, 7'h35, 7'h2C, 7'h31, 7'h32, 7'h33, 7'h23};
    apply_reset();
    ligar = 1'b1;
    do_frame(5, 12'h123, {7'h30, 7'h34, 7'h35}, -1, 1'b0);
    n_tests++;
    if (obs_expired) begin n_fail++; $display("FAIL basic_done: no fim_quadro within budget"); end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (obs_ch[i] !== want[i]) begin
        n_fail++; $display("FAIL basic_char%0d: got %h want %h", i, obs_ch[i], want[i]);
      end
    end
    n_tests++;
    if (obs_nmedir !== 1 || obs_falha !== 1'b0 || obs_unstable !== 0 || obs_nch !== 8 || obs_pos !== 2'd0) begin
      n_fail++;
      $display("FAIL basic_misc: got medirs=%0d falha=%b unstable=%0d chars=%0d pos=%0d want 1 0 0 8 0",
               obs_nmedir, obs_falha, obs_unstable, obs_nch, obs_pos);
    end
    step();
    n_tests++;
    if (fim_quadro !== 1'b0 || db_estado !== 4'd5) begin
      n_fail++; $display("FAIL fim_once: got fim=%b st=%0d want fim=0 st=5", fim_quadro, db_estado);
    end
    seen = 0;
    for (int t = 0; t < 60 && !seen; t++) begin
      step();
      if (db_estado == 4'd1) seen = 1;
    end
    n_tests++;
    if (!seen || posicao !== 2'd1) begin
      n_fail++; $display("FAIL basic_advance: got seen=%0d pos=%0d want seen=1 pos=1", seen, posicao);
    end
  endtask

  task automatic test_timeout();
    logic [20:0] ang;
    ang = 21'($urandom);
    apply_reset();
    ligar = 1'b1;
    do_frame(0, 12'h987, ang, -1, 1'b0);
    n_tests++;
    if (obs_expired || obs_nmedir !== N_TENT || obs_gap !== T_TIMEOUT || obs_falha !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_retry: got expired=%0d medirs=%0d gap=%0d falha=%b want 0 %0d %0d 1",
               obs_expired, obs_nmedir, obs_gap, obs_falha, N_TENT, T_TIMEOUT);
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (obs_ch[i] !== exp_char(i, ang, 12'h987, 1'b1)) begin
        n_fail++; $display("FAIL timeout_char%0d: got %h want %h", i, obs_ch[i], exp_char(i, ang, 12'h987, 1'b1));
      end
    end
  endtask

  task automatic test_coincident();
    logic [20:0] ang;
    ang = 21'($urandom);
    apply_reset();
    ligar = 1'b1;
    do_frame(T_TIMEOUT - 1, 12'h456, ang, -1, 1'b0);
    n_tests++;
    if (obs_expired || obs_nmedir !== 1 || obs_falha !== 1'b0) begin
      n_fail++; $display("FAIL coincident: got expired=%0d medirs=%0d falha=%b want 0 1 0",
                         obs_expired, obs_nmedir, obs_falha);
    end
    for (int i = 4; i < 7; i++) begin
      n_tests++;
      if (obs_ch[i] !== exp_char(i, ang, 12'h456, 1'b0)) begin
        n_fail++; $display("FAIL coincident_char%0d: got %h want %h", i, obs_ch[i], exp_char(i, ang, 12'h456, 1'b0));
      end
    end
  endtask

  task automatic test_sweep();
    int per, r, want;
    per = 2 * (N_POS - 1);
    for (int m = 0; m < 2; m++) begin
      apply_reset();
      modo = 1'(m);
      ligar = 1'b1;
      for (int k = 0; k < 8; k++) begin
        do_frame(2, 12'h000, 21'h0, -1, 1'b0);
        r = k % per;
        want = (m == 0) ? (k % N_POS) : ((r < N_POS) ? r : per - r);
        n_tests++;
        if (obs_expired || int'(obs_pos) !== want) begin
          n_fail++; $display("FAIL sweep_m%0d_f%0d: got pos=%0d expired=%0d want pos=%0d", m, k, obs_pos, obs_expired, want);
        end
      end
    end
  endtask

  task automatic test_ligar_off();
    apply_reset();
    ligar = 1'b1;
    do_frame(3, 12'h321, 21'h1ABCDE, 3, 1'b0);
    n_tests++;
    if (obs_expired || obs_nch !== 8 || obs_nfim !== 1) begin
      n_fail++; $display("FAIL drop_tx_finish: got expired=%0d chars=%0d fims=%0d want 0 8 1", obs_expired, obs_nch, obs_nfim);
    end
    step();
    n_tests++;
    if (db_estado !== 4'd0 || posicao !== 2'd0) begin
      n_fail++; $display("FAIL drop_tx_idle: got st=%0d pos=%0d want 0 0", db_estado, posicao);
    end
    ligar = 1'b1;
    do_frame(3, 12'h321, 21'h1ABCDE, -1, 1'b0);
    n_tests++;
    if (obs_expired || obs_pos !== 2'd0) begin
      n_fail++; $display("FAIL restart_pos: got pos=%0d expired=%0d want pos=0", obs_pos, obs_expired);
    end
    step(); step(); step();
    n_tests++;
    if (db_estado !== 4'd5) begin n_fail++; $display("FAIL espera_state: got st=%0d want 5", db_estado); end
    ligar = 1'b0;
    step();
    n_tests++;
    if (db_estado !== 4'd0 || posicao !== 2'd0 || dados_ascii !== 7'h00 || falha_medida !== 1'b0) begin
      n_fail++; $display("FAIL drop_espera: got st=%0d pos=%0d dados=%h falha=%b want 0 0 00 0",
                         db_estado, posicao, dados_ascii, falha_medida);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    apply_reset();
    ligar = 1'b1;
    do_frame(2, 12'h111, 21'h0, -1, 1'b0);
    do_frame(2, 12'h222, 21'h0, -1, 1'b0);
    seen = 0;
    for (int t = 0; t < 100 && !seen; t++) begin
      step();
      if (partida_tx) seen = 1;
    end
    step();
    n_tests++;
    if (!seen || db_estado !== 4'd4 || posicao !== 2'd2) begin
      n_fail++; $display("FAIL reset_mid_setup: got seen=%0d st=%0d pos=%0d want 1 4 2", seen, db_estado, posicao);
    end
    rst = 1'b1;
    step();
    n_tests++;
    if (db_estado !== 4'd0 || posicao !== 2'd0 || partida_tx !== 1'b0 || medir !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: got st=%0d pos=%0d partida=%b medir=%b want 0 0 0 0",
                         db_estado, posicao, partida_tx, medir);
    end
    rst = 1'b0;
    ligar = 1'b0;
  endtask

  task automatic test_random();
    int mpos, dly, sel;
    bit desce, ok, spur, fail_ch;
    logic [11:0] med;
    logic [20:0] ang;
    apply_reset();
    mpos = 0; desce = 0;
    modo = 1'($urandom);
    ligar = 1'b1;
    for (int f = 0; f < 10; f++) begin
      sel = int'($urandom_range(0, 3));
      if (sel == 0) dly = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(10, 12));
      else          dly = int'($urandom_range(1, T_TIMEOUT - 1));
      ok = (dly >= 1) && (dly <= T_TIMEOUT - 1);
      med = 12'($urandom);
      ang = 21'($urandom);
      spur = 1'($urandom);
      do_frame(dly, med, ang, -1, spur);
      fail_ch = 0;
      for (int i = 0; i < 8; i++)
        if (obs_ch[i] !== exp_char(i, ang, med, !ok)) fail_ch = 1;
      n_tests++;
      if (obs_expired || fail_ch || int'(obs_pos) !== mpos || obs_falha !== !ok ||
          obs_nmedir !== (ok ? 1 : N_TENT) || obs_unstable !== 0 || obs_nfim !== 1) begin
        n_fail++;
        $display("FAIL random_f%0d: got pos=%0d falha=%b medirs=%0d chars_bad=%0d unstable=%0d want pos=%0d falha=%b medirs=%0d (dly=%0d)",
                 f, obs_pos, obs_falha, obs_nmedir, fail_ch, obs_unstable, mpos, !ok, ok ? 1 : N_TENT, dly);
      end
      modo = 1'($urandom);
      if (modo == 1'b0) begin
        mpos = (mpos + 1) % N_POS;
      end else begin
        if (!desce && mpos == N_POS - 1) desce = 1;
        else if (desce && mpos == 0)     desce = 0;
        mpos = desce ? mpos - 1 : mpos + 1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_timeout();
    test_coincident();
    test_sweep();
    test_ligar_off();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
